seg7_mux_scheduler: RTL and testbench
=====================================

// Module: seg7_mux_scheduler
// PURPOSE
//  Time-multiplexes the two 7-segment digits (ones, tens) onto the shared segment bus.
//  Applies PWM brightness from the I2C duty register (sub-address 8, bits [6:0]).
//  Sits between the dice result registers / I2C register file and the uo_out / uio_out pads.
//  Sequences common enables with dead time so no digit ever shows the other digit's segments.
// PARAMETERS
//  PRESCALE  8  clk cycles per PWM slot (>=1); 128 slots per digit phase
//  DEADTIME  4  clk cycles with both commons inactive between phases (>=1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset, asynchronous, active-high
//  ena          in   1  design enable; low forces IDLE
//  digit1       in   4  ones digit (0-9 shown, 10-15 blank)
//  digit10      in   4  tens digit (0-9 shown, 10-15 blank)
//  duty         in   7  on-slots per 128-slot phase (0 = dark, 127 = 127/128)
//  seg_pol      in   1  segment active level (1 = active-high)
//  com_pol      in   1  common active level (1 = active-high)
//  seg          out  8  segment bus {dp,g,f,e,d,c,b,a}; dp never lit
//  com1         out  1  ones-digit common
//  com10        out  1  tens-digit common
//  frame_start  out  1  one-cycle pulse when a new frame latches inputs
// BEHAVIOUR
//  - Internal registers: lit[7:0], act1, act10, state, pre, slot[6:0], dt counter, latched d1/d10/duty.
//  - Pad outputs: seg = seg_pol ? lit : ~lit; com1 = act1 ? com_pol : ~com_pol; com10 likewise.
//  - Reset: lit=0, act1=act10=0, frame_start=0, state=IDLE, all counters 0.
//    Pads therefore show inactive levels for the current polarity inputs.
//  - FSM: IDLE -> PH1 -> GAP1 -> PH10 -> GAP10 -> PH1 ...
//  - IDLE -> PH1 on the first clk edge with ena=1; ena=0 in any state returns to IDLE
//    next edge, outputs inactive.
//  - Entering PH1 from IDLE or GAP10: latch digit1, digit10, duty; pulse frame_start for that
//    one cycle. Inputs changing mid-frame have no effect until the next frame.
//  - PHx lasts 128*PRESCALE cycles. pre counts 0..PRESCALE-1; slot increments on pre wrap.
//    Leaving PHx at slot=127 with pre wrap goes to GAPx.
//  - In PHx the phase common is active iff slot < duty_latched; the other common is always inactive.
//  - lit = decode(latched digit) only while that common is active, else 0.
//    Codes 10-15 decode to 0 (blank; common still pulses).
//  - Decode, bit order {dp,g..a}:
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//  - GAPx lasts DEADTIME cycles: act1=act10=0, lit=0.
//  - All outputs are registered, with a one-cycle delay from state/slot.
//    Never act1 & act10 simultaneously.
//  - Frame = 2*(128*PRESCALE+DEADTIME) cycles.
//  - duty=0: commons never active, lit stays 0. Only the latched duty counts.
//  - rst mid-phase: outputs inactive asynchronously; restart from IDLE.
// TESTING (PRESCALE=1, DEADTIME=2, frame=260 cycles)
//  - Reset with seg_pol=1, com_pol=0 -> seg=00, com1=com10=1 until ena. First frame_start one edge after ena=1.
//  - digit1=7, digit10=3, duty=127 -> com1 active 127 cycles with seg=07.
//    Then 1 off cycle, then 2 gap cycles, then com10 active 127 cycles with seg=4F.
//  - duty=0x2B -> each common active exactly 43 of every 260 cycles; seg=00 whenever no common is active.
//  - duty=0 -> no common active over 3 frames.
//    duty=1 -> exactly 1 active cycle per digit per frame.
//  - Change digit1 5->9 and duty mid-PH1 -> no change until the next frame_start.
//    seg_pol=0 then yields seg=~6F on com1.
//  - ena=0 mid-PH10 -> next edge both commons inactive, lit=0.
//    ena=1 -> frame_start after 1 edge; async rst mid-GAP1 likewise.
//  - All runs: assert !(act1 && act10) every cycle; digit10=12 -> com10 pulses with seg=00.

Source files
------------

// File: rtl/seg7_mux_scheduler_if.sv
// Pad-side and register-side signals of the 7-segment multiplexer, grouped as one bus.
// The master drives digits, duty, polarities and enable; the scheduler drives the pads.
interface seg7_mux_scheduler_if;
  logic       ena;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic [6:0] duty;
  logic       seg_pol;
  logic       com_pol;
  logic [7:0] seg;
  logic       com1;
  logic       com10;
  logic       frame_start;

  modport master (
    output ena, digit1, digit10, duty, seg_pol, com_pol,
    input  seg, com1, com10, frame_start
  );

  modport slave (
    input  ena, digit1, digit10, duty, seg_pol, com_pol,
    output seg, com1, com10, frame_start
  );
endinterface

// File: rtl/seg7_mux_scheduler.sv
// Two-digit 7-segment multiplexer with PWM brightness and dead time between digit phases.
// Inputs are sampled once per frame; every pad level is derived from registered state.
module seg7_mux_scheduler #(
  parameter int PRESCALE = 8,
  parameter int DEADTIME = 4
) (
  input logic                 clk,
  input logic                 rst,
  seg7_mux_scheduler_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DT_LAST  = DW'(DEADTIME - 1);

  typedef enum logic [2:0] {IDLE, PH1, GAP1, PH10, GAP10} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [6:0]      slot_q, slot_d;
  logic [DW-1:0]   dt_q, dt_d;
  logic [3:0]      d1_q, d1_d;
  logic [3:0]      d10_q, d10_d;
  logic [6:0]      duty_q, duty_d;
  logic [7:0]      lit_q, lit_d;
  logic            act1_q, act1_d;
  logic            act10_q, act10_d;
  logic            fs_q, fs_d;

  logic pre_wrap;
  logic dt_wrap;
  logic slot_on;

  function automatic logic [7:0] decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign pre_wrap = (pre_q == PRE_LAST);
  assign dt_wrap  = (dt_q == DT_LAST);
  assign slot_on  = (slot_q < duty_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    pre_d   = pre_q;
    slot_d  = slot_q;
    dt_d    = dt_q;
    d1_d    = d1_q;
    d10_d   = d10_q;
    duty_d  = duty_q;
    lit_d   = 8'h00;
    act1_d  = 1'b0;
    act10_d = 1'b0;
    fs_d    = 1'b0;

    if (!bus.ena) begin
      state_d = IDLE;
      pre_d   = '0;
      slot_d  = '0;
      dt_d    = '0;
    end else begin
      case (state_q)
        PH1, PH10: begin
          // Only the common of the current phase may light; the other stays off.
          if (state_q == PH1) begin
            act1_d = slot_on;
            lit_d  = slot_on ? decode(d1_q) : 8'h00;
          end else begin
            act10_d = slot_on;
            lit_d   = slot_on ? decode(d10_q) : 8'h00;
          end
          if (pre_wrap) begin
            pre_d  = '0;
            slot_d = slot_q + 7'd1;
            if (slot_q == 7'd127) state_d = (state_q == PH1) ? GAP1 : GAP10;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        GAP1, GAP10: begin
          if (dt_wrap) begin
            dt_d = '0;
            if (state_q == GAP1) state_d = PH10;
            else                 state_d = PH1;
          end else begin
            dt_d = dt_q + 1'b1;
          end
        end
        default: state_d = PH1;
      endcase

      // A new frame starts on entry to PH1: sample the inputs and flag it.
      if (state_q == IDLE || (state_q == GAP10 && dt_wrap)) begin
        d1_d   = bus.digit1;
        d10_d  = bus.digit10;
        duty_d = bus.duty;
        fs_d   = 1'b1;
        pre_d  = '0;
        slot_d = '0;
      end
    end
  end

  // NOTE: the asynchronous reset clears every register, including the latched inputs, so the
  // pads go inactive the moment rst rises rather than at the next clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      slot_q  <= '0;
      dt_q    <= '0;
      d1_q    <= '0;
      d10_q   <= '0;
      duty_q  <= '0;
      lit_q   <= '0;
      act1_q  <= 1'b0;
      act10_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      slot_q  <= slot_d;
      dt_q    <= dt_d;
      d1_q    <= d1_d;
      d10_q   <= d10_d;
      duty_q  <= duty_d;
      lit_q   <= lit_d;
      act1_q  <= act1_d;
      act10_q <= act10_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.seg         = bus.seg_pol ? lit_q : ~lit_q;
  assign bus.com1        = act1_q  ? bus.com_pol : ~bus.com_pol;
  assign bus.com10       = act10_q ? bus.com_pol : ~bus.com_pol;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_mux_scheduler.sv
// Frame-level scoreboard bench for seg7_mux_scheduler with PRESCALE=1, DEADTIME=2 (260-cycle frame).
// Stimulus pushes the expected per-frame summary; a negedge monitor builds the observed one.
module tb_seg7_mux_scheduler;

  logic clk;
  logic rst;

  seg7_mux_scheduler_if bus ();

  seg7_mux_scheduler #(.PRESCALE(1), .DEADTIME(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n1;
    int         n10;
    logic [7:0] s1;
    logic [7:0] s10;
    int         bad;
  } frame_t;

  frame_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     flush_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  frame_t obs;
  bit     open_w = 1'b0;
  int     flush_seen = 0;

  task automatic emit();
    frame_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_unexpected: got n1=%0d n10=%0d with no expected frame", obs.n1, obs.n10);
    end else begin
      e = exp_q.pop_front();
      check("frame_n1",  obs.n1,  e.n1);
      check("frame_n10", obs.n10, e.n10);
      check("frame_seg1",  {24'd0, obs.s1},  {24'd0, e.s1});
      check("frame_seg10", {24'd0, obs.s10}, {24'd0, e.s10});
      check("frame_bad_cycles", obs.bad, e.bad);
    end
  endtask

  initial begin
    logic       a1, a10;
    logic [7:0] blank;
    forever begin
      @(negedge clk);
      a1    = (bus.com1  == bus.com_pol);
      a10   = (bus.com10 == bus.com_pol);
      blank = bus.seg_pol ? 8'h00 : 8'hFF;
      if (a1 && a10)
        $display("FAIL both_commons: got com1=%b com10=%b both active (t=%0t)", bus.com1, bus.com10, $time);
      if (bus.frame_start) begin
        if (open_w) emit();
        obs = '{0, 0, 8'h00, 8'h00, 0};
        open_w = 1'b1;
      end
      if (open_w) begin
        if (a1 && a10) obs.bad++;
        if (a1) begin
          if (obs.n1 == 0) obs.s1 = bus.seg;
          else if (bus.seg != obs.s1) obs.bad++;
          obs.n1++;
        end
        if (a10) begin
          if (obs.n10 == 0) obs.s10 = bus.seg;
          else if (bus.seg != obs.s10) obs.bad++;
          obs.n10++;
        end
        if (!a1 && !a10 && bus.seg != blank) obs.bad++;
      end
      if (flush_seen != flush_cnt) begin
        flush_seen = flush_cnt;
        if (open_w) emit();
        open_w = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic setf(input logic [3:0] d1, input logic [3:0] d10, input logic [6:0] dty,
                      input int n1, input int n10, input logic [7:0] s1, input logic [7:0] s10);
    bus.digit1  = d1;
    bus.digit10 = d10;
    bus.duty    = dty;
    exp_q.push_back('{n1, n10, s1, s10, 0});
  endtask

  task automatic wait_fs();
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_start) got = 1'b1;
    end
    check("frame_start_timeout", {31'd0, got}, 32'd1);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.ena     = 1'b0;
    bus.seg_pol = 1'b1;
    bus.com_pol = 1'b0;
    bus.digit1  = 4'd0;
    bus.digit10 = 4'd0;
    bus.duty    = 7'd0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_seg",   {24'd0, bus.seg}, 32'h00);
    check("reset_com1",  {31'd0, bus.com1},  32'd1);
    check("reset_com10", {31'd0, bus.com10}, 32'd1);
    check("reset_fs",    {31'd0, bus.frame_start}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("idle_com1", {31'd0, bus.com1}, 32'd1);

    // F1: full brightness, 7 / 3
    setf(4'd7, 4'd3, 7'd127, 127, 127, 8'h07, 8'h4F);
    bus.ena = 1'b1;
    @(posedge clk); #1;
    check("first_fs_after_ena", {31'd0, bus.frame_start}, 32'd1);
    #1;
    setf(4'd1, 4'd0, 7'h2B, 43, 43, 8'h06, 8'h3F);   // F2
    wait_fs();
    setf(4'd8, 4'd8, 7'd0, 0, 0, 8'h00, 8'h00);      // F3
    wait_fs();
    setf(4'd8, 4'd8, 7'd0, 0, 0, 8'h00, 8'h00);      // F4
    wait_fs();
    setf(4'd8, 4'd8, 7'd0, 0, 0, 8'h00, 8'h00);      // F5
    wait_fs();
    setf(4'd2, 4'd12, 7'd1, 1, 1, 8'h5B, 8'h00);     // F6: minimum duty, blank tens
    wait_fs();
    setf(4'd5, 4'd4, 7'd64, 64, 64, 8'h6D, 8'h66);   // F7
    wait_fs();
    // Mid-frame change during F7's PH1; takes effect in F8 with inverted segments.
    setf(4'd9, 4'd4, 7'd100, 100, 100, 8'h90, 8'h99);
    wait_fs();
    bus.seg_pol = 1'b0;
    // F9 is aborted by ena=0 after 70 tens-digit cycles.
    setf(4'd6, 4'd0, 7'd127, 127, 70, 8'h82, 8'hC0);
    wait_fs();
    repeat (200) @(posedge clk);
    #2 bus.ena = 1'b0;
    @(posedge clk); #1;
    check("ena_off_com1",  {31'd0, bus.com1},  32'd1);
    check("ena_off_com10", {31'd0, bus.com10}, 32'd1);
    check("ena_off_seg",   {24'd0, bus.seg},   32'hFF);
    flush_cnt++;
    @(posedge clk); #2;

    // F10 is cut by an asynchronous reset during GAP1.
    bus.seg_pol = 1'b1;
    setf(4'd4, 4'd9, 7'd127, 127, 0, 8'h66, 8'h00);
    bus.ena = 1'b1;
    @(posedge clk); #1;
    check("fs_after_reenable", {31'd0, bus.frame_start}, 32'd1);
    #1;
    repeat (128) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_com1",  {31'd0, bus.com1},  32'd1);
    check("async_rst_com10", {31'd0, bus.com10}, 32'd1);
    check("async_rst_seg",   {24'd0, bus.seg},   32'h00);
    flush_cnt++;
    @(posedge clk); #2;
    setf(4'd0, 4'd1, 7'h2B, 43, 43, 8'h3F, 8'h06);   // F11
    rst = 1'b0;
    @(posedge clk); #1;
    check("fs_after_reset", {31'd0, bus.frame_start}, 32'd1);
    #1;
    wait_fs();
    @(negedge clk);
    @(negedge clk);
    check("pending_frames", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
